// File: rtl/cache_pkg.sv
// Shared constants, FSM state type and address field helpers for the cache controller.
package cache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned TAG_W      = 22;
  localparam int unsigned INDEX_W    = 6;
  localparam int unsigned WORD_SEL_W = 2;

  typedef enum logic [1:0] {S_IDLE, S_BACKWARD, S_FORWARD, S_WAIT} state_e;

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] index_of(input logic [ADDR_W-1:0] addr);
    return addr[WORD_SEL_W+2 +: INDEX_W];
  endfunction

  function automatic logic [WORD_SEL_W-1:0] word_of(input logic [ADDR_W-1:0] addr);
    return addr[2 +: WORD_SEL_W];
  endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU, cache-array and main-memory signal bundle seen by the cache controller.
interface cache_ctrl_if;
  import cache_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_din;
  logic [31:0]       cpu_dout;
  logic              cpu_stall;

  logic [ADDR_W-1:0] cache_addr;
  logic              cache_store;
  logic              cache_edit;
  logic              cache_invalid;
  logic [31:0]       cache_din;
  logic              cache_hit;
  logic [31:0]       cache_dout;
  logic              cache_valid;
  logic              cache_dirty;
  logic [TAG_W-1:0]  cache_tag;

  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_dout;
  logic [31:0]       mem_din;
  logic              mem_ack;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    output cpu_dout, cpu_stall,
    output cache_addr, cache_store, cache_edit, cache_invalid, cache_din,
    input  cache_hit, cache_dout, cache_valid, cache_dirty, cache_tag,
    output mem_cs, mem_we, mem_addr, mem_dout,
    input  mem_din, mem_ack
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    input  cpu_dout, cpu_stall,
    input  cache_addr, cache_store, cache_edit, cache_invalid, cache_din,
    output cache_hit, cache_dout, cache_valid, cache_dirty, cache_tag,
    input  mem_cs, mem_we, mem_addr, mem_dout,
    output mem_din, mem_ack
  );

endinterface

// File: rtl/cache_ctrl_stats.sv
// Saturating hit/miss counters; built only when CACHE_CTRL_STATS_EN is defined.
module cache_ctrl_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_hit,
  input  logic        i_miss,
  output logic [31:0] o_hit_cnt,
  output logic [31:0] o_miss_cnt
);

  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic        r_miss_pend;

  // The hit that completes a refilled miss is swallowed via r_miss_pend.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_miss_pend <= 1'b0;
    end else if (i_miss) begin
      if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
      r_miss_pend <= 1'b1;
    end else if (i_hit) begin
      if (r_miss_pend) r_miss_pend <= 1'b0;
      else if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
    end
  end

  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;

endmodule

// File: rtl/cache_ctrl.sv
// Miss sequencer for a direct-mapped write-back cache: write-back then refill per miss.
// Optional hit/miss statistics enabled by defining CACHE_CTRL_STATS_EN.
module cache_ctrl
  import cache_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  cache_ctrl_if.master bus,
  output logic [31:0]  stat_hit_cnt,
  output logic [31:0]  stat_miss_cnt
);

  state_e                r_state, w_state_next;
  logic [WORD_SEL_W-1:0] r_word_cnt, w_word_cnt_next;
  logic                  w_req;
  logic                  w_last;
  logic [INDEX_W-1:0]    w_idx;
  logic [ADDR_W-1:0]     w_bk_addr;
  logic [ADDR_W-1:0]     w_fw_addr;

  // Requests are ignored while reset is held so stall drops with reset.
  assign w_req     = bus.cpu_req & rst;
  assign w_last    = (r_word_cnt == {WORD_SEL_W{1'b1}});
  assign w_idx     = index_of(bus.cpu_addr);
  assign w_bk_addr = {bus.cache_tag, w_idx, r_word_cnt, 2'b00};
  assign w_fw_addr = {tag_of(bus.cpu_addr), w_idx, r_word_cnt, 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_word_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_word_cnt <= w_word_cnt_next;
    end
  end

  // Addresses kept apart from the hit/data decode so the cache lookup path stays acyclic.
  always_comb begin
    bus.cache_addr = bus.cpu_addr;
    bus.mem_addr   = '0;
    case (r_state)
      S_BACKWARD: begin
        bus.cache_addr = w_bk_addr;
        bus.mem_addr   = w_bk_addr;
      end
      S_FORWARD: begin
        bus.mem_addr = w_fw_addr;
        if (bus.mem_ack) bus.cache_addr = w_fw_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_next      = r_state;
    w_word_cnt_next   = r_word_cnt;
    bus.cpu_dout      = '0;
    bus.cpu_stall     = 1'b0;
    bus.cache_store   = 1'b0;
    bus.cache_edit    = 1'b0;
    bus.cache_invalid = 1'b0;
    bus.cache_din     = '0;
    bus.mem_cs        = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_dout      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (bus.cache_hit) begin
            bus.cpu_dout = bus.cache_dout;
            if (bus.cpu_we) begin
              bus.cache_edit = 1'b1;
              bus.cache_din  = bus.cpu_din;
            end
          end else begin
            bus.cpu_stall   = 1'b1;
            w_word_cnt_next = '0;
            w_state_next    = (bus.cache_valid && bus.cache_dirty) ? S_BACKWARD : S_FORWARD;
          end
        end
      end
      S_BACKWARD: begin
        bus.cpu_stall = 1'b1;
        bus.mem_cs    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_dout  = bus.cache_dout;
        if (bus.mem_ack) begin
          w_word_cnt_next = r_word_cnt + 1'b1;
          if (w_last) w_state_next = S_FORWARD;
        end
      end
      S_FORWARD: begin
        bus.cpu_stall = 1'b1;
        bus.mem_cs    = 1'b1;
        if (bus.mem_ack) begin
          bus.cache_store = 1'b1;
          bus.cache_din   = bus.mem_din;
          w_word_cnt_next = r_word_cnt + 1'b1;
          if (w_last) w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        bus.cpu_stall = 1'b1;
        w_state_next  = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

`ifdef CACHE_CTRL_STATS_EN
  logic w_hit_done;
  logic w_miss_start;

  assign w_hit_done   = (r_state == S_IDLE) & w_req & bus.cache_hit;
  assign w_miss_start = (r_state == S_IDLE) & w_req & ~bus.cache_hit;

  cache_ctrl_stats u_stats (
    .clk        (clk),
    .rst        (rst),
    .i_hit      (w_hit_done),
    .i_miss     (w_miss_start),
    .o_hit_cnt  (stat_hit_cnt),
    .o_miss_cnt (stat_miss_cnt)
  );
`else
  assign stat_hit_cnt  = '0;
  assign stat_miss_cnt = '0;
`endif

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Initiator-side controller for the direct-mapped write-back `cache` block. It drives `cache`'s addr/store/edit/invalid/din and reads back hit/dout/valid/dirty/tag.
- Sits between the CPU data port and the word-wide main-memory port, issuing a line write-back then a line refill on every miss.
- The cache itself holds only data and tag; all miss sequencing lives in this block.

Parameters:
- ADDR_W, 32, byte address width
- TAG_W, 22, tag width; must equal `cache` tag port width
- INDEX_W, 6, line index bits
- WORD_SEL_W, 2, word-in-line select bits; 4 words per line. Byte offset is 2 bits, so TAG_W+INDEX_W+WORD_SEL_W+2 = ADDR_W.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU access request; held until cpu_stall=0
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  byte address, word aligned
- cpu_din  in  32  write data
- cpu_dout  out  32  read data
- cpu_stall  out  1  access not yet complete
- cache_addr  out  ADDR_W  to cache addr
- cache_store  out  1  refill write; cache sets valid=1, dirty=0
- cache_edit  out  1  CPU write; cache sets dirty=1
- cache_invalid  out  1  clear valid of addressed line
- cache_din  out  32  to cache din
- cache_hit  in  1  from cache
- cache_dout  in  32  from cache, combinational read
- cache_valid  in  1  from cache
- cache_dirty  in  1  from cache
- cache_tag  in  TAG_W  stored tag of addressed line
- mem_cs  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory word address
- mem_dout  out  32  data to memory
- mem_din  in  32  data from memory
- mem_ack  in  1  one-cycle completion pulse

Behaviour:
- States: S_IDLE, S_BACKWARD, S_FORWARD, S_WAIT. Internal registers: state, word_cnt (WORD_SEL_W bits).
- Reset (rst=0, async): state=S_IDLE, word_cnt=0. All registered outputs 0.
- Outputs are combinational from state/inputs. With cpu_req=0 in S_IDLE, every output is 0 except cache_addr=cpu_addr.
- S_IDLE, cpu_req=1, cache_hit=1:
  - cpu_stall=0, cpu_dout=cache_dout.
  - If cpu_we=1: cache_edit=1, cache_din=cpu_din, same cycle.
  - Zero added latency; stay in S_IDLE.
- S_IDLE, cpu_req=1, cache_hit=0:
  - cpu_stall=1, word_cnt<=0.
  - valid&dirty -> S_BACKWARD; otherwise -> S_FORWARD.
- S_BACKWARD:
  - cache_addr={cache_tag, cpu index, word_cnt, 2'b00}; mem_addr=same; mem_cs=1, mem_we=1, mem_dout=cache_dout.
  - On mem_ack: word_cnt++. After last word (word_cnt wraps to 0) -> S_FORWARD.
- S_FORWARD:
  - mem_addr={cpu tag, index, word_cnt, 2'b00}; mem_cs=1, mem_we=0.
  - On mem_ack: cache_store=1, cache_addr=mem_addr, cache_din=mem_din, word_cnt++. After last word -> S_WAIT.
- S_WAIT: one re-lookup cycle; cpu_stall=1, cache_addr=cpu_addr; -> S_IDLE. The next cycle then hits.
- mem_cs/mem_we/mem_addr are stable from issue until the mem_ack cycle. The next word is issued on the cycle after the ack.
- cpu_stall=1 in every state other than S_IDLE.
- CPU inputs must stay stable while stalled; a change is unsupported (not checked).
- Clean miss costs 4 ack-waits + 1 cycle. Dirty miss adds 4 more.
- cache_invalid is never asserted by the FSM (tied 0; reserved for flush).
- Reset mid-miss returns to S_IDLE immediately. The partially refilled line is left as written; the cache's own reset clears valid.
- mem_ack outside S_BACKWARD/S_FORWARD is ignored.

Optional Feature:
- Macro: CACHE_CTRL_STATS_EN.
- Defined:
  - 32-bit outputs stat_hit_cnt and stat_miss_cnt.
  - hit counter increments once per completed access that hit in S_IDLE, i.e. excluding the S_IDLE cycle after S_WAIT that completes a miss.
  - miss counter increments on each S_IDLE->miss transition.
  - Both saturate at 32'hFFFF_FFFF, reset to 0, and start counting after reset release.
- Undefined: ports present but tied to 0; no counter flops.

Decomposition:
- Shared package cache_pkg: ADDR_W/TAG_W/INDEX_W/WORD_SEL_W constants; state enum; field-extract functions tag_of, index_of, word_of.
- One sub-module is natural: cache_ctrl_stats, the saturating counter pair, instantiated only under the macro.

Test Plan:
- Reset then read 0x0000_0000 on an empty cache -> S_FORWARD; mem_addr 0x00, 0x04, 0x08, 0x0C; 4 cache_store pulses; S_WAIT; cpu_dout=mem word 0; no write-back.
- Write 0x3333_3333 to 0x0000_0004 after line loaded -> cache_edit=1 same cycle, cpu_stall=0; read-back returns 0x3333_3333.
- Read 0x0000_0404 (same index, tag 1) with dirty line -> 4 mem writes at 0x00..0x0C, mem_dout word1=0x3333_3333; then 4 reads at 0x400..0x40C.
- mem_ack delayed 3 cycles per word -> mem_addr/mem_cs held stable; 16 S_FORWARD cycles observed for a clean miss.
- Assert rst=0 during S_BACKWARD word 2 -> mem_cs=0 and cpu_stall=0 same cycle; state S_IDLE.
- With CACHE_CTRL_STATS_EN: 1 miss + 3 hits -> stat_miss_cnt=1, stat_hit_cnt=3.
